// File: rtl/integer_issue_pkg.sv
// Shared types for the integer issue queue: field widths, queue entry and dispatch payload.
package integer_issue_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned ROB_INDEX_WIDTH     = 8;
  localparam int unsigned DECODED_INSTR_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH       = 4;

  typedef logic [XLEN-1:0]                xlen_t;
  typedef logic [ROB_INDEX_WIDTH-1:0]     rob_idx_t;
  typedef logic [DECODED_INSTR_WIDTH-1:0] opcode_t;

  typedef struct packed {
    logic     valid;
    logic     rdy1;
    logic     rdy2;
    xlen_t    val1;
    xlen_t    val2;
    rob_idx_t tag1;
    rob_idx_t tag2;
    opcode_t  opcode;
    rob_idx_t rob;
    xlen_t    pc;
  } iq_entry_t;

  typedef struct packed {
    logic     valid;
    xlen_t    val1;
    xlen_t    val2;
    opcode_t  opcode;
    rob_idx_t rob;
    xlen_t    pc;
  } disp_t;

  function automatic logic tag_hit(input logic cdb_valid, input rob_idx_t cdb_tag,
                                   input rob_idx_t tag);
    return cdb_valid && (cdb_tag == tag);
  endfunction

endpackage

// File: rtl/integer_issue_queue_if.sv
// Rename, CDB and dispatch signals of the integer issue queue; the queue uses the slave modport.
interface integer_issue_queue_if;
  import integer_issue_pkg::*;

  logic     rename_valid;
  logic     rename_ready;
  opcode_t  rename_decoded_instruction;
  rob_idx_t rename_ROB_index;
  xlen_t    rename_PC;
  logic     rename_1st_ready;
  logic     rename_2nd_ready;
  xlen_t    rename_1st_value;
  xlen_t    rename_2nd_value;
  rob_idx_t rename_1st_tag;
  rob_idx_t rename_2nd_tag;

  logic     cdb_valid;
  rob_idx_t cdb_ROB_index;
  xlen_t    cdb_value;

  logic     dispatch_valid;
  logic     dispatch_ready;
  xlen_t    dispatch_1st_reg;
  xlen_t    dispatch_2nd_reg;
  opcode_t  dispatch_decoded_instruction;
  rob_idx_t dispatch_ROB_index;
  xlen_t    dispatch_PC_i;

  modport master (
    output rename_valid, rename_decoded_instruction, rename_ROB_index, rename_PC,
           rename_1st_ready, rename_2nd_ready, rename_1st_value, rename_2nd_value,
           rename_1st_tag, rename_2nd_tag, cdb_valid, cdb_ROB_index, cdb_value, dispatch_ready,
    input  rename_ready, dispatch_valid, dispatch_1st_reg, dispatch_2nd_reg,
           dispatch_decoded_instruction, dispatch_ROB_index, dispatch_PC_i
  );

  modport slave (
    input  rename_valid, rename_decoded_instruction, rename_ROB_index, rename_PC,
           rename_1st_ready, rename_2nd_ready, rename_1st_value, rename_2nd_value,
           rename_1st_tag, rename_2nd_tag, cdb_valid, cdb_ROB_index, cdb_value, dispatch_ready,
    output rename_ready, dispatch_valid, dispatch_1st_reg, dispatch_2nd_reg,
           dispatch_decoded_instruction, dispatch_ROB_index, dispatch_PC_i
  );

endinterface

// File: rtl/integer_issue_select.sv
// Oldest-ready priority encoder; INTEGER_ISSUE_QUEUE_INORDER_EN restricts selection to entry 0.
module integer_issue_select #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [DEPTH-1:0] eligible;

`ifdef INTEGER_ISSUE_QUEUE_INORDER_EN
  assign eligible = {{(DEPTH-1){1'b0}}, ready_i[0]};
`else
  assign eligible = ready_i;
`endif

  // Scan from the top so the lowest (oldest) eligible index wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/integer_issue_queue.sv
// Collapsing integer reservation station with CDB wakeup and a registered dispatch stage.
// Optional macro: INTEGER_ISSUE_QUEUE_INORDER_EN (strict in-order issue from entry 0).
module integer_issue_queue
  import integer_issue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned OccW = $clog2(DEPTH + 1),
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  integer_issue_queue_if.slave   bus,
  output logic [OccW-1:0]        occupancy
);

  iq_entry_t        entries_q [DEPTH];
  iq_entry_t        entries_d [DEPTH];
  iq_entry_t        woke      [DEPTH];
  iq_entry_t        shifted   [DEPTH];
  iq_entry_t        new_entry;
  disp_t            disp_q, disp_d;
  logic [OccW-1:0]  occ_q, occ_d, wr_idx;
  logic [DEPTH-1:0] ready_vec;
  logic             sel_valid, take, issue, alloc;
  logic [IdxW-1:0]  sel_idx;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entries_q[i].valid && entries_q[i].rdy1 && entries_q[i].rdy2;
    end
  end

  integer_issue_select #(.DEPTH(DEPTH)) u_select (
    .ready_i (ready_vec),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  assign bus.rename_ready = !reset && (occ_q < OccW'(DEPTH));
  assign take   = !disp_q.valid || bus.dispatch_ready;
  assign issue  = sel_valid && take && !flush;
  assign alloc  = bus.rename_valid && bus.rename_ready && !flush;
  assign wr_idx = occ_q - OccW'(issue);

  // Incoming operands may be woken by the broadcast of the same cycle.
  always_comb begin
    new_entry        = '0;
    new_entry.valid  = 1'b1;
    new_entry.rdy1   = bus.rename_1st_ready ||
                       tag_hit(bus.cdb_valid, bus.cdb_ROB_index, bus.rename_1st_tag);
    new_entry.rdy2   = bus.rename_2nd_ready ||
                       tag_hit(bus.cdb_valid, bus.cdb_ROB_index, bus.rename_2nd_tag);
    new_entry.val1   = bus.rename_1st_ready ? bus.rename_1st_value : bus.cdb_value;
    new_entry.val2   = bus.rename_2nd_ready ? bus.rename_2nd_value : bus.cdb_value;
    new_entry.tag1   = bus.rename_1st_tag;
    new_entry.tag2   = bus.rename_2nd_tag;
    new_entry.opcode = bus.rename_decoded_instruction;
    new_entry.rob    = bus.rename_ROB_index;
    new_entry.pc     = bus.rename_PC;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = entries_q[i];
      if (woke[i].valid && !woke[i].rdy1 &&
          tag_hit(bus.cdb_valid, bus.cdb_ROB_index, woke[i].tag1)) begin
        woke[i].rdy1 = 1'b1;
        woke[i].val1 = bus.cdb_value;
      end
      if (woke[i].valid && !woke[i].rdy2 &&
          tag_hit(bus.cdb_valid, bus.cdb_ROB_index, woke[i].tag2)) begin
        woke[i].rdy2 = 1'b1;
        woke[i].val2 = bus.cdb_value;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = woke[i+1];
    end
    shifted[DEPTH-1] = '0;
  end

  // Entries above the issuing slot collapse down; the new entry fills the first free slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = (issue && (IdxW'(i) >= sel_idx)) ? shifted[i] : woke[i];
      if (alloc && (OccW'(i) == wr_idx)) begin
        entries_d[i] = new_entry;
      end
      if (flush) begin
        entries_d[i] = '0;
      end
    end
  end

  always_comb begin
    occ_d  = flush ? '0 : occ_q + OccW'(alloc) - OccW'(issue);
    disp_d = disp_q;
    if (flush) begin
      disp_d = '0;
    end else if (take) begin
      disp_d.valid = issue;
      if (issue) begin
        disp_d.val1   = entries_q[sel_idx].val1;
        disp_d.val2   = entries_q[sel_idx].val2;
        disp_d.opcode = entries_q[sel_idx].opcode;
        disp_d.rob    = entries_q[sel_idx].rob;
        disp_d.pc     = entries_q[sel_idx].pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q  <= '0;
      disp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      occ_q  <= occ_d;
      disp_q <= disp_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  assign occupancy                        = occ_q;
  assign bus.dispatch_valid               = disp_q.valid;
  assign bus.dispatch_1st_reg             = disp_q.val1;
  assign bus.dispatch_2nd_reg             = disp_q.val2;
  assign bus.dispatch_decoded_instruction = disp_q.opcode;
  assign bus.dispatch_ROB_index           = disp_q.rob;
  assign bus.dispatch_PC_i                = disp_q.pc;

endmodule

// File: tb/tb_integer_issue_queue.sv
// Bench for integer_issue_queue: directed table, hand sequences and a random run vs a queue model.
module tb_integer_issue_queue;
  import integer_issue_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned OccW  = $clog2(Depth + 1);
`ifdef INTEGER_ISSUE_QUEUE_INORDER_EN
  localparam int Window = 1;
`else
  localparam int Window = Depth;
`endif

  logic            clock = 1'b0;
  logic            reset, flush;
  logic [OccW-1:0] occupancy;

  integer_issue_queue_if bus ();

  integer_issue_queue #(.DEPTH(Depth)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic rst; logic fl; logic rv; rob_idx_t rob; opcode_t op; xlen_t pc;
    logic r1; xlen_t v1; rob_idx_t t1; logic r2; xlen_t v2; rob_idx_t t2;
    logic cv; rob_idx_t crob; xlen_t cval; logic dr;
  } stim_t;

  typedef struct packed {
    logic r1; logic r2; xlen_t v1; xlen_t v2; rob_idx_t t1; rob_idx_t t2;
    opcode_t op; rob_idx_t rob; xlen_t pc;
  } ment_t;

  typedef struct packed {
    stim_t s; logic dv; rob_idx_t rob; xlen_t v1; xlen_t v2; logic [3:0] occ;
  } vec_t;

  ment_t    mq[$];
  logic     m_dv = 1'b0;
  ment_t    m_disp = '0;
  rob_idx_t log_q[$];
  int       n_pass = 0;
  int       n_total = 0;
  vec_t     tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s    = '0;
    s.dr = 1'b1;
    return s;
  endfunction

  function automatic stim_t ren(input rob_idx_t rob, input opcode_t op, input logic r1,
                                input xlen_t v1, input rob_idx_t t1, input logic r2,
                                input xlen_t v2, input rob_idx_t t2);
    stim_t s;
    s     = idle();
    s.rv  = 1'b1;
    s.rob = rob;  s.op = op;  s.pc = xlen_t'(32'h1000) + xlen_t'(rob) * 4;
    s.r1  = r1;   s.v1 = v1;  s.t1 = t1;
    s.r2  = r2;   s.v2 = v2;  s.t2 = t2;
    return s;
  endfunction

  function automatic stim_t with_cdb(input stim_t s, input rob_idx_t tag, input xlen_t val);
    stim_t r;
    r      = s;
    r.cv   = 1'b1;
    r.crob = tag;
    r.cval = val;
    return r;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic dv, input rob_idx_t rob,
                               input xlen_t v1, input xlen_t v2, input logic [3:0] occ);
    vec_t v;
    v.s = s; v.dv = dv; v.rob = rob; v.v1 = v1; v.v2 = v2; v.occ = occ;
    return v;
  endfunction

  // One clock of the reference: oldest ready entry in the window leaves, then wakeup, then append.
  task automatic model_step(input stim_t s);
    int    sel;
    logic  acc;
    ment_t e;
    if (s.rst || s.fl) begin
      mq.delete();
      m_dv = 1'b0;
      if (s.rst) m_disp = '0;
    end else begin
      acc = s.rv && (mq.size() < Depth);
      if (!m_dv || s.dr) begin
        sel = -1;
        for (int i = 0; i < Window && i < mq.size(); i++) begin
          if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
        end
        m_dv = (sel >= 0);
        if (sel >= 0) begin
          m_disp = mq[sel];
          mq.delete(sel);
        end
      end
      foreach (mq[i]) begin
        if (s.cv && !mq[i].r1 && mq[i].t1 == s.crob) begin mq[i].r1 = 1'b1; mq[i].v1 = s.cval; end
        if (s.cv && !mq[i].r2 && mq[i].t2 == s.crob) begin mq[i].r2 = 1'b1; mq[i].v2 = s.cval; end
      end
      if (acc) begin
        e.t1 = s.t1; e.t2 = s.t2; e.op = s.op; e.rob = s.rob; e.pc = s.pc;
        e.r1 = s.r1 || (s.cv && s.crob == s.t1);
        e.r2 = s.r2 || (s.cv && s.crob == s.t2);
        e.v1 = s.r1 ? s.v1 : s.cval;
        e.v2 = s.r2 ? s.v2 : s.cval;
        mq.push_back(e);
      end
    end
  endtask

  task automatic cycle(input stim_t s);
    reset                          = s.rst;
    flush                          = s.fl;
    bus.rename_valid               = s.rv;
    bus.rename_ROB_index           = s.rob;
    bus.rename_decoded_instruction = s.op;
    bus.rename_PC                  = s.pc;
    bus.rename_1st_ready           = s.r1;
    bus.rename_1st_value           = s.v1;
    bus.rename_1st_tag             = s.t1;
    bus.rename_2nd_ready           = s.r2;
    bus.rename_2nd_value           = s.v2;
    bus.rename_2nd_tag             = s.t2;
    bus.cdb_valid                  = s.cv;
    bus.cdb_ROB_index              = s.crob;
    bus.cdb_value                  = s.cval;
    bus.dispatch_ready             = s.dr;
    if (bus.dispatch_valid === 1'b1 && s.dr && !s.rst && !s.fl) log_q.push_back(bus.dispatch_ROB_index);
    model_step(s);
    @(posedge clock);
    @(negedge clock);
    check("dispatch_valid", 64'(bus.dispatch_valid), 64'(m_dv));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("rename_ready", 64'(bus.rename_ready), 64'(!s.rst && mq.size() < Depth));
    if (m_dv) begin
      check("dispatch_rob", 64'(bus.dispatch_ROB_index), 64'(m_disp.rob));
      check("dispatch_op1", 64'(bus.dispatch_1st_reg), 64'(m_disp.v1));
      check("dispatch_op2", 64'(bus.dispatch_2nd_reg), 64'(m_disp.v2));
      check("dispatch_opcode", 64'(bus.dispatch_decoded_instruction), 64'(m_disp.op));
      check("dispatch_pc", 64'(bus.dispatch_PC_i), 64'(m_disp.pc));
    end
  endtask

  initial begin
    stim_t s;

    // Reset: outputs idle and payloads cleared, rename_ready low while held.
    s = idle();
    s.rst = 1'b1;
    cycle(s);
    cycle(s);
    check("reset_op1", 64'(bus.dispatch_1st_reg), 64'd0);
    check("reset_rob", 64'(bus.dispatch_ROB_index), 64'd0);
    check("reset_pc", 64'(bus.dispatch_PC_i), 64'd0);
    cycle(idle());
    check("post_reset_rr", 64'(bus.rename_ready), 64'd1);

    // Directed table: ready issue, CDB wakeup, same-cycle bypass.
    tbl[0]  = mkv(ren(11, 0, 1, 17, 0, 1, 18, 0),                1'b0, 0, 0, 0, 1);
    tbl[1]  = mkv(idle(),                                        1'b1, 11, 17, 18, 0);
    tbl[2]  = mkv(idle(),                                        1'b0, 0, 0, 0, 0);
    tbl[3]  = mkv(ren(12, 14, 0, 0, 11, 1, 6, 0),                1'b0, 0, 0, 0, 1);
    tbl[4]  = mkv(idle(),                                        1'b0, 0, 0, 0, 1);
    tbl[5]  = mkv(with_cdb(idle(), 11, 35),                      1'b0, 0, 0, 0, 1);
    tbl[6]  = mkv(idle(),                                        1'b1, 12, 35, 6, 0);
    tbl[7]  = mkv(idle(),                                        1'b0, 0, 0, 0, 0);
    tbl[8]  = mkv(with_cdb(ren(25, 3, 0, 0, 30, 1, 7, 0), 30, 99), 1'b0, 0, 0, 0, 1);
    tbl[9]  = mkv(idle(),                                        1'b1, 25, 99, 7, 0);
    tbl[10] = mkv(idle(),                                        1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].s);
      check($sformatf("vec%0d_valid", i), 64'(bus.dispatch_valid), 64'(tbl[i].dv));
      check($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
      if (tbl[i].dv) begin
        check($sformatf("vec%0d_rob", i), 64'(bus.dispatch_ROB_index), 64'(tbl[i].rob));
        check($sformatf("vec%0d_op1", i), 64'(bus.dispatch_1st_reg), 64'(tbl[i].v1));
        check($sformatf("vec%0d_op2", i), 64'(bus.dispatch_2nd_reg), 64'(tbl[i].v2));
      end
    end

    // Younger ready instruction overtakes an older waiting one (unless in-order).
    log_q.delete();
    cycle(ren(13, 1, 0, 0, 40, 1, 2, 0));
    cycle(ren(14, 2, 1, 3, 0, 1, 4, 0));
    cycle(idle());
    cycle(with_cdb(idle(), 40, 5));
    repeat (4) cycle(idle());
    check("ooo_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
`ifdef INTEGER_ISSUE_QUEUE_INORDER_EN
      check("ooo_first", 64'(log_q[0]), 64'd13);
      check("ooo_second", 64'(log_q[1]), 64'd14);
`else
      check("ooo_first", 64'(log_q[0]), 64'd14);
      check("ooo_second", 64'(log_q[1]), 64'd13);
`endif
    end

    // Backpressure: fill the queue behind a stalled dispatch, then drain back-to-back.
    for (int k = 0; k < 6; k++) begin
      s = ren(rob_idx_t'(20 + k), 5, 1, xlen_t'(100 + k), 0, 1, xlen_t'(200 + k), 0);
      s.dr = 1'b0;
      cycle(s);
      if (k >= 1) check("hold_rob", 64'(bus.dispatch_ROB_index), 64'd20);
    end
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_rr", 64'(bus.rename_ready), 64'd0);
    log_q.delete();
    repeat (5) cycle(idle());
    check("drain_count", 64'(log_q.size()), 64'd5);
    for (int k = 0; k < 5 && k < log_q.size(); k++) begin
      check("drain_order", 64'(log_q[k]), 64'(20 + k));
    end
    cycle(idle());

    // Flush with a concurrent rename drops everything.
    for (int k = 0; k < 4; k++) begin
      s = ren(rob_idx_t'(50 + k), 6, 1, 1, 0, 1, 2, 0);
      s.dr = 1'b0;
      cycle(s);
    end
    check("pre_flush_occ", 64'(occupancy), 64'd3);
    check("pre_flush_valid", 64'(bus.dispatch_valid), 64'd1);
    s = ren(60, 7, 1, 9, 0, 1, 9, 0);
    s.dr = 1'b0;
    s.fl = 1'b1;
    cycle(s);
    check("flush_valid", 64'(bus.dispatch_valid), 64'd0);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_rr", 64'(bus.rename_ready), 64'd1);
    log_q.delete();
    repeat (4) cycle(idle());
    check("flush_dropped", 64'(log_q.size()), 64'd0);

    // Random traffic against the queue model.
    for (int n = 0; n < 2000; n++) begin
      s      = idle();
      s.dr   = ($urandom_range(0, 3) != 0);
      s.rv   = $urandom_range(0, 1) == 1;
      s.rob  = rob_idx_t'($urandom);
      s.op   = opcode_t'($urandom);
      s.pc   = $urandom;
      s.r1   = $urandom_range(0, 1) == 1;
      s.v1   = $urandom;
      s.t1   = rob_idx_t'($urandom_range(0, 7));
      s.r2   = $urandom_range(0, 1) == 1;
      s.v2   = $urandom;
      s.t2   = rob_idx_t'($urandom_range(0, 7));
      s.cv   = $urandom_range(0, 1) == 1;
      s.crob = rob_idx_t'($urandom_range(0, 7));
      s.cval = $urandom;
      s.fl   = $urandom_range(0, 99) == 0;
      s.rst  = $urandom_range(0, 299) == 0;
      cycle(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
